// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor: widths, mux/ALU encodings and
// the opcode map used by both the control block and the datapath.
package bip_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 11;

   localparam logic [1:0] SELA_RAM = 2'b00;
   localparam logic [1:0] SELA_IMM = 2'b01;
   localparam logic [1:0] SELA_ALU = 2'b10;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [4:0] {
      OPC_HLT  = 5'd0,
      OPC_STO  = 5'd1,
      OPC_LD   = 5'd2,
      OPC_LDI  = 5'd3,
      OPC_ADD  = 5'd4,
      OPC_ADDI = 5'd5,
      OPC_SUB  = 5'd6,
      OPC_SUBI = 5'd7
   } bip_opcode_e;

   // Two's-complement overflow from operand and result sign bits only.
   function automatic logic alu_ovf(input logic sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
      if (sub)
         return (a_msb != b_msb) && (r_msb != a_msb);
      else
         return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/bip_data_ram.sv
// BIP data RAM: synchronous write, asynchronous (distributed) read.
// Writes are blocked while rst is asserted; contents survive reset.
module bip_data_ram #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 11,
   parameter int RAM_DEPTH = 2048
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [RAM_DEPTH];

   // NOTE: the array has no reset branch on purpose -- clearing it would
   // prevent mapping onto RAM primitives, and program data must persist.
   always_ff @(posedge clk) begin
      if (we && !rst)
         mem_q[addr] <= wdata;
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/bip_datapath.sv
// BIP accumulator datapath: operand muxes, add/sub ALU, accumulator with
// Zero and sticky Ovf flags, and the data RAM. One instruction per cycle.
module bip_datapath #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 11,
   parameter int RAM_DEPTH = 2048
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        SelA,
   input  logic              SelB,
   input  logic              WrAcc,
   input  logic              Op,
   input  logic              WrRam,
   input  logic              RdRam,
   input  logic [ADDR_W-1:0] Addr,
   output logic [DATA_W-1:0] Acc,
   output logic [DATA_W-1:0] RamData,
   output logic              Zero,
   output logic              Ovf
);

   import bip_pkg::*;

   logic [DATA_W-1:0] acc_q, acc_d;
   logic              zero_q;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] imm, ram_rd, op_b, alu;

   bip_data_ram #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .RAM_DEPTH(RAM_DEPTH)
   ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (WrRam),
      .addr (Addr),
      .wdata(acc_q),
      .rdata(ram_rd)
   );

   assign imm     = {{(DATA_W-ADDR_W){Addr[ADDR_W-1]}}, Addr};
   assign RamData = RdRam ? ram_rd : '0;
   assign op_b    = SelB ? imm : RamData;
   assign alu     = (Op == OP_SUB) ? acc_q - op_b : acc_q + op_b;

   // NOTE: hold values are assigned first so every path drives acc_d and
   // ovf_d; otherwise SelA=11 would infer a latch.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (WrAcc) begin
         case (SelA)
            SELA_RAM: acc_d = RamData;
            SELA_IMM: acc_d = imm;
            SELA_ALU: begin
               acc_d = alu;
               ovf_d = ovf_q | alu_ovf(Op == OP_SUB, acc_q[DATA_W-1],
                                       op_b[DATA_W-1], alu[DATA_W-1]);
            end
            default: acc_d = acc_q;
         endcase
      end
   end

   // Zero is computed from the next value so it lines up with Acc.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         zero_q <= 1'b1;
         ovf_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         zero_q <= (acc_d == '0);
         ovf_q  <= ovf_d;
      end
   end

   assign Acc  = acc_q;
   assign Zero = zero_q;
   assign Ovf  = ovf_q;

endmodule

// File: tb/tb_bip_datapath.sv
// Scoreboard bench for bip_datapath: integer reference model, directed
// scenarios, then randomized instruction streams.
module tb_bip_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  SelA;
   logic        SelB, WrAcc, Op, WrRam, RdRam;
   logic [10:0] Addr;
   logic [15:0] Acc, RamData;
   logic        Zero, Ovf;

   bip_datapath dut (
      .clk    (clk),
      .rst    (rst),
      .SelA   (SelA),
      .SelB   (SelB),
      .WrAcc  (WrAcc),
      .Op     (Op),
      .WrRam  (WrRam),
      .RdRam  (RdRam),
      .Addr   (Addr),
      .Acc    (Acc),
      .RamData(RamData),
      .Zero   (Zero),
      .Ovf    (Ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [15:0] acc;
      logic        zero;
      logic        ovf;
   } st_exp_t;

   typedef struct {
      int          due;
      logic [15:0] rd;
   } rd_exp_t;

   st_exp_t st_q[$];
   rd_exp_t rd_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: plain integers, -1 marks an unwritten RAM word.
   int acc_m = 0;
   int ovf_m = 0;
   int ram_m [2048];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sgn(input int x);
      return (x >= 32768) ? x - 65536 : x;
   endfunction

   function automatic int sext11(input int a);
      return (a >= 1024) ? a - 2048 + 65536 : a;
   endfunction

   // Drive one instruction cycle and record what the DUT must show.
   task automatic step(input logic r, input logic [1:0] sa, input logic sb,
                       input logic wa, input logic o, input logic wr,
                       input logic rr, input logic [10:0] ad);
      int a, imm_m, rd_m, b, s;
      st_exp_t se;
      rd_exp_t re;
      rst = r; SelA = sa; SelB = sb; WrAcc = wa; Op = o;
      WrRam = wr; RdRam = rr; Addr = ad;
      a     = int'(ad);
      imm_m = sext11(a);
      rd_m  = rr ? ram_m[a] : 0;
      if (rd_m >= 0) begin
         re.due = cyc;
         re.rd  = 16'(rd_m);
         rd_q.push_back(re);
      end
      if (r) begin
         acc_m = 0;
         ovf_m = 0;
      end else begin
         if (wr) ram_m[a] = acc_m;
         if (wa) begin
            case (sa)
               2'd0: acc_m = rd_m;
               2'd1: acc_m = imm_m;
               2'd2: begin
                  b = sb ? imm_m : rd_m;
                  s = o ? sgn(acc_m) - sgn(b) : sgn(acc_m) + sgn(b);
                  if (s > 32767 || s < -32768) ovf_m = 1;
                  acc_m = (((o ? acc_m - b : acc_m + b) % 65536) + 65536) % 65536;
               end
               default: ;
            endcase
         end
      end
      se.due  = cyc + 1;
      se.acc  = 16'(acc_m);
      se.zero = (acc_m == 0);
      se.ovf  = (ovf_m != 0);
      st_q.push_back(se);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every due expectation on the falling edge.
   initial begin
      rd_exp_t re;
      st_exp_t se;
      forever begin
         @(negedge clk);
         while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            re = rd_q.pop_front();
            check("ramdata", RamData, re.rd);
         end
         while (st_q.size() > 0 && st_q[0].due <= cyc) begin
            se = st_q.pop_front();
            check("acc", Acc, se.acc);
            check("zero", Zero, se.zero);
            check("ovf", Ovf, se.ovf);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 2048; i++) ram_m[i] = -1;
      rst = 1'b1; SelA = 2'b00; SelB = 1'b0; WrAcc = 1'b0; Op = 1'b0;
      WrRam = 1'b0; RdRam = 1'b0; Addr = '0;
      @(posedge clk);
      @(posedge clk);
      #1;

      // Reset beats a pending immediate load.
      step(1, 2'b01, 0, 1, 0, 0, 0, 11'd5);
      check("rst_acc", Acc, 16'h0000);
      check("rst_zero", Zero, 1'b1);
      check("rst_ovf", Ovf, 1'b0);

      // Fill RAM: each cycle stores the old Acc and loads Addr as immediate.
      for (int a = 0; a < 2048; a++) step(0, 2'b01, 0, 1, 0, 1, 0, 11'(a));

      step(0, 2'b01, 0, 1, 0, 0, 0, 11'h7FF);
      check("ldi_m1", Acc, 16'hFFFF);
      step(0, 2'b00, 0, 0, 0, 1, 0, 11'd3);
      step(0, 2'b00, 0, 1, 0, 0, 1, 11'd3);
      check("ld_ram3", Acc, 16'hFFFF);

      step(0, 2'b01, 0, 1, 0, 0, 0, 11'd10);
      step(0, 2'b10, 1, 1, 0, 0, 0, 11'd5);
      check("addi5", Acc, 16'd15);
      step(0, 2'b00, 0, 0, 0, 1, 0, 11'd3);
      step(0, 2'b10, 0, 1, 1, 0, 1, 11'd3);
      check("sub_zero_acc", Acc, 16'd0);
      check("sub_zero_flag", Zero, 1'b1);

      // Reach 0x7FFF without overflow: 1023 doubled 5 times, plus 31.
      step(0, 2'b01, 0, 1, 0, 0, 0, 11'd1023);
      for (int k = 0; k < 5; k++) begin
         step(0, 2'b00, 0, 0, 0, 1, 0, 11'd0);
         step(0, 2'b10, 0, 1, 0, 0, 1, 11'd0);
      end
      step(0, 2'b10, 1, 1, 0, 0, 0, 11'd31);
      check("max_pos", Acc, 16'h7FFF);
      check("no_ovf_yet", Ovf, 1'b0);
      step(0, 2'b10, 1, 1, 0, 0, 0, 11'd1);
      check("wrap_acc", Acc, 16'h8000);
      check("ovf_set", Ovf, 1'b1);
      step(0, 2'b01, 0, 1, 0, 0, 0, 11'd0);
      check("ovf_sticky", Ovf, 1'b1);
      step(0, 2'b10, 1, 1, 1, 0, 0, 11'd1);
      check("subi_wrap", Acc, 16'hFFFF);

      step(0, 2'b01, 0, 1, 0, 0, 0, 11'd7);
      step(0, 2'b01, 0, 1, 0, 1, 0, 11'd9);
      check("sim_acc", Acc, 16'd9);
      step(0, 2'b00, 0, 1, 0, 0, 1, 11'd9);
      check("sim_ram9", Acc, 16'd7);
      step(0, 2'b11, 0, 1, 0, 0, 1, 11'd9);
      check("sela11_hold", Acc, 16'd7);
      step(0, 2'b00, 0, 1, 0, 0, 0, 11'd9);
      check("rdram_off", Acc, 16'd0);

      step(0, 2'b01, 0, 1, 0, 0, 0, 11'h55);
      step(0, 2'b00, 0, 0, 0, 1, 0, 11'd4);
      step(0, 2'b01, 0, 1, 0, 0, 0, 11'h66);
      step(1, 2'b01, 0, 1, 0, 1, 0, 11'd4);
      check("rst_mid_acc", Acc, 16'd0);
      step(0, 2'b00, 0, 1, 0, 0, 1, 11'd4);
      check("rst_mid_ram4", Acc, 16'h0055);

      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)));
      end

      WrAcc = 1'b0; WrRam = 1'b0; RdRam = 1'b0; rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("drain", 32'(rd_q.size() + st_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
